// File: rtl/branch_tag_tracker.sv
// Decode-stage branch tag allocator and tracker: hands out in-order tags, builds
// per-lane dependency masks, resolves branches and raises a registered flush for the oldest mispredict.
module branch_tag_tracker #(
  parameter int DEC_WIDTH = 2,
  parameter int MAX_BR    = 4,
  parameter int RES_PORTS = 2,
  parameter int TAG_W     = $clog2(MAX_BR)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DEC_WIDTH-1:0]           alloc_req_i,
  input  logic                           alloc_fire_i,
  output logic                           stall_o,
  output logic [DEC_WIDTH*TAG_W-1:0]     alloc_tag_o,
  output logic [DEC_WIDTH*MAX_BR-1:0]    dep_mask_o,
  input  logic [RES_PORTS-1:0]           res_valid_i,
  input  logic [RES_PORTS*TAG_W-1:0]     res_tag_i,
  input  logic [RES_PORTS-1:0]           res_mispredict_i,
  input  logic [RES_PORTS*32-1:0]        res_target_i,
  output logic                           flush_o,
  output logic [31:0]                    flush_addr_o,
  output logic [TAG_W-1:0]               flush_tag_o,
  output logic [MAX_BR-1:0]              kill_mask_o,
  output logic [TAG_W:0]                 inflight_o
);

  localparam int CW = TAG_W + 1;
  localparam int SW = $clog2(DEC_WIDTH + MAX_BR + 1);
  localparam int RW = (RES_PORTS < MAX_BR) ? RES_PORTS : MAX_BR;

  logic [MAX_BR-1:0] valid_q, resolved_q;
  logic [TAG_W-1:0]  head_q, tail_q;
  logic [CW-1:0]     cnt_q;

  logic [SW-1:0]     need, free_cnt;
  logic [MAX_BR-1:0] alloc_mask;
  logic              commit;

  logic              mis_any;
  logic [TAG_W-1:0]  win_tag, win_off;
  logic [31:0]       win_addr;
  logic [MAX_BR-1:0] kill, res_set, retire, win_oh;
  logic [CW-1:0]     n_kill, n_ret;

  // Lane i's tag is tail plus the number of requesting lanes below it.
  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin : alloc_logic
    logic [TAG_W-1:0]  lane_tag;
    logic [MAX_BR-1:0] older;
    need        = '0;
    older       = '0;
    lane_tag    = '0;
    alloc_tag_o = '0;
    dep_mask_o  = '0;
    for (int i = 0; i < DEC_WIDTH; i++) begin
      lane_tag = tail_q + TAG_W'(need);
      alloc_tag_o[i*TAG_W +: TAG_W]  = lane_tag;
      dep_mask_o[i*MAX_BR +: MAX_BR] = (valid_q & ~resolved_q) | older;
      if (alloc_req_i[i]) begin
        older[lane_tag] = 1'b1;
        need            = need + SW'(1);
      end
    end
    alloc_mask = older;
  end

  assign free_cnt   = SW'(MAX_BR) - SW'(cnt_q);
  assign stall_o    = (need > free_cnt) | flush_o;
  assign commit     = alloc_fire_i & ~stall_o & ~mis_any;
  assign inflight_o = cnt_q;

  // Oldest mispredict wins: age is the tag's distance from head.
  always_comb begin : resolve_logic
    logic [TAG_W-1:0] ptag, poff, koff;
    mis_any  = 1'b0;
    win_tag  = '0;
    win_off  = '0;
    win_addr = '0;
    res_set  = '0;
    kill     = '0;
    n_kill   = '0;
    ptag     = '0;
    poff     = '0;
    koff     = '0;
    for (int p = 0; p < RES_PORTS; p++) begin
      ptag = res_tag_i[p*TAG_W +: TAG_W];
      poff = ptag - head_q;
      if (res_valid_i[p] && valid_q[ptag] && !(flush_o && kill_mask_o[ptag]))
        res_set[ptag] = 1'b1;
      if (res_valid_i[p] && res_mispredict_i[p] && valid_q[ptag] && (!mis_any || poff < win_off)) begin
        mis_any  = 1'b1;
        win_tag  = ptag;
        win_off  = poff;
        win_addr = res_target_i[p*32 +: 32];
      end
    end
    for (int k = 0; k < MAX_BR; k++) begin
      koff    = TAG_W'(k) - head_q;
      kill[k] = mis_any && valid_q[k] && (koff > win_off);
      n_kill  = n_kill + CW'(kill[k]);
    end
    win_oh = '0;
    if (mis_any) win_oh[win_tag] = 1'b1;
  end

  always_comb begin : retire_logic
    logic             go;
    logic [TAG_W-1:0] idx;
    go     = 1'b1;
    idx    = '0;
    retire = '0;
    n_ret  = '0;
    for (int r = 0; r < RW; r++) begin
      idx = head_q + TAG_W'(r);
      if (go && valid_q[idx] && resolved_q[idx]) begin
        retire[idx] = 1'b1;
        n_ret       = n_ret + CW'(1);
      end else begin
        go = 1'b0;
      end
    end
  end

  // NOTE: the per-entry valid bits are real state, not storage, so they must reset like any flop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      resolved_q   <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= '0;
      flush_o      <= 1'b0;
      flush_addr_o <= '0;
      flush_tag_o  <= '0;
      kill_mask_o  <= '0;
    end else begin
      valid_q    <= (valid_q & ~retire & ~kill) | (commit ? alloc_mask : '0);
      resolved_q <= (resolved_q | res_set | win_oh) & ~(commit ? alloc_mask : '0);
      head_q     <= head_q + TAG_W'(n_ret);
      if (mis_any)     tail_q <= win_tag + TAG_W'(1);
      else if (commit) tail_q <= tail_q + TAG_W'(need);
      cnt_q       <= cnt_q + (commit ? CW'(need) : '0) - n_ret - n_kill;
      flush_o     <= mis_any;
      kill_mask_o <= kill;
      if (mis_any) begin
        flush_addr_o <= win_addr;
        flush_tag_o  <= win_tag;
      end
    end
  end

endmodule
